// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int MAX_READ  = 4;
    localparam int MAX_WRITE = 2;

    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer: walks clear_idx over every register after reset or a clear request,
// then holds READY until the next request.
//
//  state | meaning
//  CLEAR | zeroing regs[clear_idx] each cycle; port accesses ignored
//  READY | clear done; reads and writes honoured
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS = 32,
    localparam int ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              ready,
    output logic              clear_we,
    output logic [ADDR_W-1:0] clear_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            CLEAR: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = READY;
                    idx_d   = '0;
                end
            end
            READY: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    assign ready     = (state_q == READY);
    assign clear_we  = (state_q == CLEAR);
    assign clear_idx = idx_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with registered reads and a sequential clear engine.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter  int WORDSIZE  = 64,
    parameter  int NUM_REGS  = 32,
    parameter  int NUM_READ  = 2,
    parameter  int NUM_WRITE = 1,
    parameter  int ZERO_REG  = 1,
    localparam int ADDR_W    = addr_w(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear_req,
    input  logic [NUM_WRITE-1:0]          write_en,
    input  logic [NUM_WRITE*ADDR_W-1:0]   write_addr,
    input  logic [NUM_WRITE*WORDSIZE-1:0] write_data,
    input  logic [NUM_READ*ADDR_W-1:0]    read_addr,
    output logic [NUM_READ*WORDSIZE-1:0]  read_data,
    output logic                          ready
);

    logic [WORDSIZE-1:0]          regs_q [NUM_REGS];
    logic [NUM_READ*WORDSIZE-1:0] read_data_q, read_data_d;
    logic [WORDSIZE-1:0]          rd_val;
    logic                         clear_we;
    logic [ADDR_W-1:0]            clear_idx;

    function automatic logic is_x0(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    regfile_clear_ctrl #(
        .NUM_REGS (NUM_REGS)
    ) u_clear_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .ready     (ready),
        .clear_we  (clear_we),
        .clear_idx (clear_idx)
    );

    // Ports are visited in ascending order so the highest-index port wins a collision.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clear_we) begin
                regs_q[clear_idx] <= '0;
            end else if (ready) begin
                for (int p = 0; p < NUM_WRITE; p++) begin
                    if (write_en[p] && !is_x0(write_addr[p*ADDR_W +: ADDR_W])) begin
                        regs_q[write_addr[p*ADDR_W +: ADDR_W]] <= write_data[p*WORDSIZE +: WORDSIZE];
                    end
                end
            end
        end
    end

    always_comb begin
        read_data_d = '0;
        rd_val      = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            rd_val = regs_q[read_addr[r*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < NUM_WRITE; p++) begin
                if (ready && write_en[p] &&
                    (write_addr[p*ADDR_W +: ADDR_W] == read_addr[r*ADDR_W +: ADDR_W])) begin
                    rd_val = write_data[p*WORDSIZE +: WORDSIZE];
                end
            end
`endif
            if (is_x0(read_addr[r*ADDR_W +: ADDR_W])) begin
                rd_val = '0;
            end
            if (ready) begin
                read_data_d[r*WORDSIZE +: WORDSIZE] = rd_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_data_q <= '0;
        end else begin
            read_data_q <= read_data_d;
        end
    end

    assign read_data = read_data_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp (2 read ports, 2 write ports, hardwired x0).
module tb_register_file_mp;

    localparam int NREGS = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear_req;
    logic [1:0]   write_en;
    logic [9:0]   write_addr;
    logic [127:0] write_data;
    logic [9:0]   read_addr;
    logic [127:0] read_data;
    logic         ready;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rdy;
        logic [63:0] d0;
        logic [63:0] d1;
    } exp_t;

    exp_t exp_q[$];

    register_file_mp #(
        .WORDSIZE  (64),
        .NUM_REGS  (NREGS),
        .NUM_READ  (2),
        .NUM_WRITE (2),
        .ZERO_REG  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_req  (clear_req),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register contents plus a count of clear cycles left.
    logic [63:0] m_regs [NREGS];
    int          m_left  = 0;
    bit          m_known = 1'b0;

    function automatic logic [63:0] m_read(input logic [4:0] a);
        logic [63:0] v;
        v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < 2; p++)
            if (write_en[p] && write_addr[p*5 +: 5] == a) v = write_data[p*64 +: 64];
`endif
        if (a == 5'd0) v = 64'd0;
        return v;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_known = 1'b1;
                m_left  = NREGS;
                for (int i = 0; i < NREGS; i++) m_regs[i] = 64'd0;
                e = '{rdy: 1'b0, d0: 64'd0, d1: 64'd0};
                exp_q.push_back(e);
            end else if (m_known) begin
                if (m_left > 0) begin
                    m_left--;
                    e = '{rdy: (m_left == 0), d0: 64'd0, d1: 64'd0};
                end else begin
                    e.d0 = m_read(read_addr[4:0]);
                    e.d1 = m_read(read_addr[9:5]);
                    for (int p = 0; p < 2; p++)
                        if (write_en[p] && write_addr[p*5 +: 5] != 5'd0)
                            m_regs[write_addr[p*5 +: 5]] = write_data[p*64 +: 64];
                    if (clear_req) begin
                        m_left = NREGS;
                        for (int i = 0; i < NREGS; i++) m_regs[i] = 64'd0;
                    end
                    e.rdy = (m_left == 0);
                end
                exp_q.push_back(e);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ready", {63'd0, ready}, {63'd0, e.rdy});
                chk("rd0", read_data[63:0], e.d0);
                chk("rd1", read_data[127:64], e.d1);
            end
        end
    end

    task automatic drive(input logic rst, input logic clr, input logic [1:0] we,
                         input logic [4:0] wa0, input logic [63:0] wd0,
                         input logic [4:0] wa1, input logic [63:0] wd1,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        rst_n      = rst;
        clear_req  = clr;
        write_en   = we;
        write_addr = {wa1, wa0};
        write_data = {wd1, wd0};
        read_addr  = {ra1, ra0};
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        drive(1, 0, 2'b00, 0, 0, 0, 0, a0, a1);
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        drive(1, 0, 2'b01, a, d, 0, 0, 0, 0);
    endtask

    initial begin
        logic [4:0] a0, a1, b0, b1;
        drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(34);

        // preload, then a 1-cycle reset must re-zero everything
        for (int i = 0; i < NREGS; i++) wr(5'(i), {$urandom, $urandom});
        drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 34; i++) rd(5'(i % 16), 5'(i % 16 + 16));
        for (int i = 0; i < 16; i++) rd(5'(i), 5'(i + 16));

        // write/read latency
        wr(5, 64'hDEAD_BEEF_0000_0001);
        rd(5, 0);
        rd(0, 5);

        // x0 discard
        wr(0, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(0, 0);

        // two-port collision
        drive(1, 0, 2'b11, 7, 64'd1, 7, 64'd2, 0, 0);
        rd(7, 7);

        // same-cycle write and read of x9
        wr(9, 64'd3);
        drive(1, 0, 2'b01, 9, 64'd4, 0, 0, 9, 9);
        rd(9, 9);

        // clear request with a concurrent write, writes during clear, reset mid-clear
        wr(3, 64'd8);
        drive(1, 1, 2'b01, 4, 64'd6, 0, 0, 3, 4);
        for (int i = 0; i < 10; i++) drive(1, 0, 2'b11, 3, 64'd9, 4, 64'd9, 3, 4);
        drive(0, 0, 2'b00, 0, 0, 0, 0, 3, 4);
        for (int i = 0; i < 33; i++) drive(1, 0, 2'b01, 3, 64'd9, 0, 0, 3, 4);
        rd(3, 4);
        rd(3, 4);

        // randomized traffic; narrow address ranges provoke collisions and bypass hits
        for (int i = 0; i < 1500; i++) begin
            a0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            b0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            b1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 399) != 0), ($urandom_range(0, 99) == 0),
                  2'($urandom_range(0, 3)), a0, {$urandom, $urandom}, a1, {$urandom, $urandom},
                  b0, b1);
        end
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
